stereo_sbs_splitter: RTL and testbench

- Consumes the side-by-side stereo video stream from the HDMI input stage: `de`/`hs`/`vs` plus 8-bit RGB. The left camera occupies columns 0..HALF_W-1 and the right camera occupies HALF_W..IMG_W-1.
- Converts each pixel to 8-bit luma.
- Buffers the left half-line in a line RAM.
- While the right half arrives, emits column-aligned (left_y, right_y) pairs with coordinates. This is the input format of the SGM cost stage.

---
 rtl/sgm_video_pkg.sv | 27 ++
 rtl/rgb_to_luma.sv | 64 ++++++
 rtl/stereo_sbs_splitter.sv | 182 ++++++++++++++++++
 tb/tb_stereo_sbs_splitter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgm_video_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sgm_video_pkg
// Description : Shared pixel/luma constants and the stereo pair record.
// Revision    : 1.0  initial release
// ============================================================================
package sgm_video_pkg;

    localparam int          c_pix_w      = 8;
    localparam logic [15:0] c_luma_kr    = 16'd77;
    localparam logic [15:0] c_luma_kg    = 16'd150;
    localparam logic [15:0] c_luma_kb    = 16'd29;
    localparam int          c_luma_shift = 8;
    localparam int          c_coord_w    = 16;

    typedef struct packed {
        logic                 valid;
        logic [c_pix_w-1:0]   left;
        logic [c_pix_w-1:0]   right;
        logic [c_coord_w-1:0] x;
        logic [c_coord_w-1:0] y;
        logic                 frame_start;
        logic                 line_end;
    } pair_t;

endpackage
`default_nettype wire

// File: rtl/rgb_to_luma.sv
`default_nettype none
// ============================================================================
// Module      : rgb_to_luma
// Description : Two-stage RGB to 8-bit luma with a side tag delayed in step.
// Revision    : 1.0  initial release
// ============================================================================
module rgb_to_luma
    import sgm_video_pkg::*;
#(
    parameter int TAG_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [c_pix_w-1:0] i_r,
    input  logic [c_pix_w-1:0] i_g,
    input  logic [c_pix_w-1:0] i_b,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_valid,
    output logic [c_pix_w-1:0] o_y,
    output logic [TAG_W-1:0]   o_tag
);

    logic               r_s1_valid;
    logic [15:0]        r_s1_pr;
    logic [15:0]        r_s1_pg;
    logic [15:0]        r_s1_pb;
    logic [TAG_W-1:0]   r_s1_tag;
    logic               r_s2_valid;
    logic [c_pix_w-1:0] r_s2_y;
    logic [TAG_W-1:0]   r_s2_tag;
    logic [15:0]        w_sum;

    // Coefficients sum to 256, so the 16-bit sum never overflows.
    assign w_sum = r_s1_pr + r_s1_pg + r_s1_pb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_pr    <= '0;
            r_s1_pg    <= '0;
            r_s1_pb    <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
            r_s2_tag   <= '0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_pr    <= c_luma_kr * 16'(i_r);
            r_s1_pg    <= c_luma_kg * 16'(i_g);
            r_s1_pb    <= c_luma_kb * 16'(i_b);
            r_s1_tag   <= i_tag;
            r_s2_valid <= r_s1_valid;
            r_s2_y     <= c_pix_w'(w_sum >> c_luma_shift);
            r_s2_tag   <= r_s1_tag;
        end
    end

    assign o_valid = r_s2_valid;
    assign o_y     = r_s2_y;
    assign o_tag   = r_s2_tag;

endmodule
`default_nettype wire

// File: rtl/stereo_sbs_splitter.sv
`default_nettype none
// ============================================================================
// Module      : stereo_sbs_splitter
// Description : Splits a side-by-side stereo line into column-aligned luma pairs.
// Revision    : 1.0  initial release
// ============================================================================
module stereo_sbs_splitter
    import sgm_video_pkg::*;
#(
    parameter  int IMG_W  = 800,
    parameter  int IMG_H  = 300,
    localparam int HALF_W = IMG_W / 2,
    localparam int XW     = $clog2(HALF_W),
    localparam int YW     = $clog2(IMG_H)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_de,
    input  logic               in_hs,
    input  logic               in_vs,
    input  logic [c_pix_w-1:0] in_r,
    input  logic [c_pix_w-1:0] in_g,
    input  logic [c_pix_w-1:0] in_b,
    output logic               pair_valid,
    output logic [c_pix_w-1:0] left_y,
    output logic [c_pix_w-1:0] right_y,
    output logic [XW-1:0]      pair_x,
    output logic [YW-1:0]      pair_y,
    output logic               frame_start,
    output logic               line_end,
    output logic               err_long,
    output logic               err_short
);

    localparam int XIW   = $clog2(IMG_W + 1);
    localparam int TAG_W = 1 + XW + YW;

    logic               r_de_d;
    logic               r_vs_d;
    logic               r_synced;
    logic               r_err_long;
    logic               r_err_short;
    logic [XIW-1:0]     r_x_in;
    logic [YW-1:0]      r_line;

    logic               w_vs_rise;
    logic               w_de_fall;
    logic               w_in_left;
    logic               w_in_active;
    logic               w_pix_valid;
    logic [XIW-1:0]     w_col_full;
    logic [XW-1:0]      w_col;
    logic [TAG_W-1:0]   w_tag_in;
    logic [TAG_W-1:0]   w_tag_out;

    logic               w_l_valid;
    logic [c_pix_w-1:0] w_l_y;
    logic               w_l_right;
    logic [XW-1:0]      w_l_col;
    logic [YW-1:0]      w_l_line;

    logic [c_pix_w-1:0] r_ram [HALF_W];
    logic [c_pix_w-1:0] r_rd_left;
    logic               r_s3_valid;
    logic [c_pix_w-1:0] r_s3_right_y;
    logic [XW-1:0]      r_s3_x;
    logic [YW-1:0]      r_s3_y;
    pair_t              r_pair;
    logic               w_unused_bits;

    always_comb begin
        w_vs_rise   = in_vs & ~r_vs_d;
        w_de_fall   = ~in_de & r_de_d;
        w_in_left   = (r_x_in < XIW'(HALF_W));
        w_in_active = (r_x_in < XIW'(IMG_W));
        w_pix_valid = r_synced & in_de & w_in_active;
        w_col_full  = w_in_left ? r_x_in : (r_x_in - XIW'(HALF_W));
        w_col       = w_col_full[XW-1:0];
        w_tag_in    = {~w_in_left, w_col, r_line};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de_d      <= 1'b0;
            r_vs_d      <= 1'b0;
            r_synced    <= 1'b0;
            r_err_long  <= 1'b0;
            r_err_short <= 1'b0;
            r_x_in      <= '0;
            r_line      <= '0;
        end else begin
            r_de_d <= in_de;
            r_vs_d <= in_vs;

            if (w_de_fall) begin
                r_x_in <= '0;
            end else if (in_de && (r_x_in != XIW'(IMG_W))) begin
                r_x_in <= r_x_in + 1'b1;
            end

            // vs wins over a coincident line end so the frame always starts at line 0.
            if (w_vs_rise) begin
                r_synced <= 1'b1;
                r_line   <= '0;
            end else if (r_synced && w_de_fall) begin
                r_line <= (r_line == YW'(IMG_H - 1)) ? '0 : r_line + 1'b1;
            end

            if (r_synced && w_de_fall && w_in_active) begin
                r_err_short <= 1'b1;
            end
            if (r_synced && in_de && !w_in_active) begin
                r_err_long <= 1'b1;
            end
        end
    end

    rgb_to_luma #(
        .TAG_W (TAG_W)
    ) u_luma (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_pix_valid),
        .i_r     (in_r),
        .i_g     (in_g),
        .i_b     (in_b),
        .i_tag   (w_tag_in),
        .o_valid (w_l_valid),
        .o_y     (w_l_y),
        .o_tag   (w_tag_out)
    );

    assign w_l_right = w_tag_out[TAG_W-1];
    assign w_l_col   = w_tag_out[XW+YW-1:YW];
    assign w_l_line  = w_tag_out[YW-1:0];

    // Read-first line RAM; left writes and right reads of one line never share an address.
    always_ff @(posedge clk) begin
        if (w_l_valid && !w_l_right) begin
            r_ram[w_l_col] <= w_l_y;
        end
        r_rd_left <= r_ram[w_l_col];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_valid   <= 1'b0;
            r_s3_right_y <= '0;
            r_s3_x       <= '0;
            r_s3_y       <= '0;
            r_pair       <= '0;
        end else begin
            r_s3_valid   <= w_l_valid & w_l_right;
            r_s3_right_y <= w_l_y;
            r_s3_x       <= w_l_col;
            r_s3_y       <= w_l_line;

            r_pair.valid       <= r_s3_valid;
            r_pair.left        <= r_rd_left;
            r_pair.right       <= r_s3_right_y;
            r_pair.x           <= c_coord_w'(r_s3_x);
            r_pair.y           <= c_coord_w'(r_s3_y);
            r_pair.frame_start <= r_s3_valid && (r_s3_x == '0) && (r_s3_y == '0);
            r_pair.line_end    <= r_s3_valid && (r_s3_x == XW'(HALF_W - 1));
        end
    end

    assign pair_valid  = r_pair.valid;
    assign left_y      = r_pair.left;
    assign right_y     = r_pair.right;
    assign pair_x      = r_pair.x[XW-1:0];
    assign pair_y      = r_pair.y[YW-1:0];
    assign frame_start = r_pair.frame_start;
    assign line_end    = r_pair.line_end;
    assign err_long    = r_err_long;
    assign err_short   = r_err_short;

    // Lines are delimited by in_de edges alone, so in_hs has no consumer.
    assign w_unused_bits = ^{r_pair.x, r_pair.y, w_col_full, in_hs};

endmodule
`default_nettype wire

// File: tb/tb_stereo_sbs_splitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stereo_sbs_splitter
// Description : Randomised self-checking bench with a line-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stereo_sbs_splitter;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 2;
    localparam int HALF_W = IMG_W / 2;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       in_de = 1'b0;
    logic       in_hs = 1'b0;
    logic       in_vs = 1'b0;
    logic [7:0] in_r  = '0;
    logic [7:0] in_g  = '0;
    logic [7:0] in_b  = '0;
    logic       pair_valid;
    logic [7:0] left_y;
    logic [7:0] right_y;
    logic [1:0] pair_x;
    logic [0:0] pair_y;
    logic       frame_start;
    logic       line_end;
    logic       err_long;
    logic       err_short;

    stereo_sbs_splitter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_de       (in_de),
        .in_hs       (in_hs),
        .in_vs       (in_vs),
        .in_r        (in_r),
        .in_g        (in_g),
        .in_b        (in_b),
        .pair_valid  (pair_valid),
        .left_y      (left_y),
        .right_y     (right_y),
        .pair_x      (pair_x),
        .pair_y      (pair_y),
        .frame_start (frame_start),
        .line_end    (line_end),
        .err_long    (err_long),
        .err_short   (err_short)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  l;
        logic [7:0]  r;
        logic [1:0]  x;
        logic [0:0]  y;
        logic        fs;
        logic        le;
        logic [31:0] cyc;
    } exp_t;

    exp_t obs_q[$];
    exp_t exp_q[$];
    int   cyc      = 0;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    // Reference model state
    bit   m_synced = 0;
    int   m_line   = 0;
    int   m_x      = 0;
    int   m_left[HALF_W];
    bit   m_elong  = 0;
    bit   m_eshort = 0;
    bit   de_prev  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pair_valid)
            obs_q.push_back(exp_t'{left_y, right_y, pair_x, pair_y, frame_start, line_end, 32'(cyc)});
    end

    function automatic int luma(input int r, input int g, input int b);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    task automatic m_pix(input int r, input int g, input int b, input int scyc);
        int y;
        y = luma(r, g, b);
        if (m_synced) begin
            if (m_x < HALF_W)
                m_left[m_x] = y;
            else if (m_x < IMG_W)
                exp_q.push_back(exp_t'{8'(m_left[m_x - HALF_W]), 8'(y), 2'(m_x - HALF_W), 1'(m_line),
                                       (m_x == HALF_W) && (m_line == 0), (m_x == IMG_W - 1), 32'(scyc + 3)});
            else
                m_elong = 1;
        end
        if (m_x < IMG_W) m_x++;
    endtask

    task automatic m_fall();
        if (m_synced) begin
            if (m_x < IMG_W) m_eshort = 1;
            m_line = (m_line + 1) % IMG_H;
        end
        m_x = 0;
    endtask

    task automatic pix(input int r, input int g, input int b);
        @(negedge clk);
        in_de = 1'b1;
        in_r  = 8'(r);
        in_g  = 8'(g);
        in_b  = 8'(b);
        de_prev = 1;
        m_pix(r, g, b, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_de = 1'b0;
            if (de_prev) m_fall();
            de_prev = 0;
        end
    endtask

    task automatic vsync();
        idle(2);
        @(negedge clk);
        in_vs    = 1'b1;
        m_synced = 1;
        m_line   = 0;
        @(negedge clk);
        in_vs = 1'b0;
        idle(2);
    endtask

    // mode 0: random RGB, 1: grey ramp 10*column, 2: red/blue with white last column
    task automatic send_line(input int n, input int mode, input int gap_at);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) idle(2);
            case (mode)
                0: pix(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
                1: pix(10 * i, 10 * i, 10 * i);
                default: begin
                    if (i == HALF_W - 1 || i == IMG_W - 1) pix(255, 255, 255);
                    else if (i < HALF_W)                   pix(255, 0, 0);
                    else                                   pix(0, 0, 255);
                end
            endcase
        end
        idle(6);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        chk_cnt++;
        if ({pair_valid, left_y, right_y, pair_x, pair_y, frame_start, line_end, err_long, err_short} !== '0)
            $display("FAIL reset_outputs: got %h want 0",
                     {pair_valid, left_y, right_y, pair_x, pair_y, frame_start, line_end, err_long, err_short});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        chk_cnt++;
        if ({pair_valid, err_long, err_short} !== 3'b000)
            $display("FAIL reset_release: got %b want 000", {pair_valid, err_long, err_short});
        else pass_cnt++;
    endtask

    task automatic test_no_sync();
        obs_q.delete(); exp_q.delete();
        send_line(IMG_W, 0, -1);
        send_line(IMG_W, 0, -1);
        chk_cnt++;
        if (obs_q.size() != 0) $display("FAIL nosync_quiet: got %0d pairs want 0", obs_q.size());
        else pass_cnt++;
        vsync();
        send_line(IMG_W, 0, -1);
        chk_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL nosync_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk_cnt++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL nosync_pair%0d: got %h want %h (l,r,x,y,fs,le,cyc)", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_basic();
        obs_q.delete(); exp_q.delete();
        vsync();
        send_line(IMG_W, 1, -1);
        send_line(IMG_W, 1, -1);
        chk_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk_cnt++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL basic_pair%0d: got %h want %h (l,r,x,y,fs,le,cyc)", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (obs_q.size() < 2 || obs_q[1].l !== 8'd10 || obs_q[1].r !== 8'd50)
            $display("FAIL basic_ramp_value: got size=%0d want pair1 (10,50)", obs_q.size());
        else pass_cnt++;
        chk_cnt++;
        if ({err_long, err_short} !== 2'b00) $display("FAIL basic_no_err: got %b want 00", {err_long, err_short});
        else pass_cnt++;
    endtask

    task automatic test_colors();
        obs_q.delete(); exp_q.delete();
        vsync();
        send_line(IMG_W, 2, -1);
        chk_cnt++;
        if (obs_q.size() != 4 || obs_q[0].l !== 8'd76 || obs_q[0].r !== 8'd28 ||
            obs_q[3].l !== 8'd255 || obs_q[3].r !== 8'd255)
            $display("FAIL colors_luma: got size=%0d want red=76 blue=28 white=255", obs_q.size());
        else pass_cnt++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk_cnt++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL colors_pair%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        obs_q.delete(); exp_q.delete();
        vsync();
        for (int k = 0; k < 5; k++) send_line(IMG_W, 0, -1);
        chk_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk_cnt++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL random_pair%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_long();
        obs_q.delete(); exp_q.delete();
        vsync();
        send_line(IMG_W + 2, 0, -1);
        chk_cnt++;
        if (obs_q.size() != 4 || obs_q.size() != exp_q.size())
            $display("FAIL long_count: got %0d want 4", obs_q.size());
        else pass_cnt++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk_cnt++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL long_pair%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (err_long !== 1'b1 || err_short !== 1'b0)
            $display("FAIL long_flag: got long=%b short=%b want 1 0", err_long, err_short);
        else pass_cnt++;
        send_line(IMG_W, 0, -1);
        chk_cnt++;
        if (err_long !== 1'b1) $display("FAIL long_sticky: got %b want 1", err_long);
        else pass_cnt++;
    endtask

    task automatic test_short();
        obs_q.delete(); exp_q.delete();
        send_line(IMG_W - 2, 0, -1);
        chk_cnt++;
        if (obs_q.size() != 2) $display("FAIL short_count: got %0d want 2", obs_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (err_short !== 1'b1) $display("FAIL short_flag: got %b want 1", err_short);
        else pass_cnt++;
        send_line(IMG_W, 0, -1);
        chk_cnt++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 6)
            $display("FAIL short_recover_count: got %0d want 6", obs_q.size());
        else pass_cnt++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk_cnt++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL short_pair%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_gap();
        obs_q.delete(); exp_q.delete();
        vsync();
        send_line(IMG_W, 0, HALF_W + 2);
        send_line(IMG_W, 0, -1);
        chk_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL gap_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk_cnt++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL gap_pair%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        obs_q.delete(); exp_q.delete();
        vsync();
        for (int i = 0; i < HALF_W + 2; i++)
            pix(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        @(negedge clk);
        rst = 1'b1;
        in_de = 1'b0;
        m_synced = 0; m_x = 0; m_line = 0; m_elong = 0; m_eshort = 0; de_prev = 0;
        exp_q.delete();
        #1;
        chk_cnt++;
        if ({pair_valid, left_y, right_y, err_long, err_short} !== '0)
            $display("FAIL midreset_clear: got %h want 0", {pair_valid, left_y, right_y, err_long, err_short});
        else pass_cnt++;
        idle(2);
        rst = 1'b0;
        idle(2);
        send_line(IMG_W, 0, -1);
        chk_cnt++;
        if (obs_q.size() != 0) $display("FAIL midreset_quiet: got %0d pairs want 0", obs_q.size());
        else pass_cnt++;
        vsync();
        send_line(IMG_W, 0, -1);
        chk_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL midreset_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk_cnt++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].y !== 1'b0)
                $display("FAIL midreset_pair%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_no_sync();
        test_basic();
        test_colors();
        test_random();
        test_long();
        test_short();
        test_gap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
